// File: rtl/tusca_controller.sv
// tusca_controller: DHT11 reader feeding a banded fan PWM, UART-programmable fan table and a servo PWM.
module tusca_controller #(
  parameter int PERIODO_DELAY = 3500,
  parameter int TIMEOUT = 5000000,
  parameter int START_CYCLES = 900000,
  parameter int BIT_ONE_CYCLES = 2000,
  parameter int CLKS_PER_BIT = 434,
  parameter int FAN_STEP = 250,
  parameter int SERVO_PERIOD = 1000000,
  parameter int SERVO_CENTRE = 75000,
  parameter int SERVO_MIN = 50000,
  parameter int SERVO_MAX = 100000,
  parameter int SWEEP_PERIODS = 50
) (
  input logic clock,
  input logic reset,
  input logic start,
  input logic gira,
  input logic rx_serial_config,
  inout wire dht_bus,
  output logic erro_config,
  output logic rele,
  output logic pwm_ventoinha,
  output logic pwm_servo,
  output logic [2:0] db_nivel_temperatura,
  output logic db_erro_medida
);
  typedef enum logic [2:0] {IDLE, START_LOW, RELEASE, WAIT_RESP_LOW, WAIT_RESP_HIGH, READ_BITS, CHECK, DELAY} state_t;
  state_t state, state_n;
  logic [31:0] cnt, ucnt, fcnt, scnt, nper;
  logic [39:0] frame;
  logic [5:0] nbits;
  logic [7:0] temp, lo;
  logic [8:0] ush;
  logic [3:0] ubit, lvl;
  logic [3:0] tbl [8];
  logic bus_s1, bus, hi, have_temp, abort, rx_s1, rx, ubusy, lo_ok, have_lo, side;
  assign dht_bus = state == START_LOW ? 1'b0 : 1'bz;
  // WAIT_RESP_HIGH and READ_BITS both track low/high phases of the sensor line
  wire ph = state == WAIT_RESP_HIGH || state == READ_BITS;
  wire fall = ph && hi && !bus;
  wire rb_fall = state == READ_BITS && fall;
  wire wait_st = state == RELEASE || state == WAIT_RESP_LOW || ph;
  wire [7:0] sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
  always_comb begin
    state_n = state;
    abort = 1'b0;
    case (state)
      IDLE: state_n = start ? START_LOW : IDLE;
      START_LOW: state_n = cnt == 32'(START_CYCLES - 1) ? RELEASE : START_LOW;
      RELEASE: state_n = bus ? WAIT_RESP_LOW : RELEASE;
      WAIT_RESP_LOW: state_n = !bus ? WAIT_RESP_HIGH : WAIT_RESP_LOW;
      WAIT_RESP_HIGH: state_n = fall ? READ_BITS : WAIT_RESP_HIGH;
      READ_BITS: state_n = rb_fall && nbits == 6'd39 ? CHECK : READ_BITS;
      CHECK: state_n = DELAY;
      DELAY: state_n = cnt == 32'(PERIODO_DELAY - 1) ? START_LOW : DELAY;
      default: state_n = IDLE;
    endcase
    if (wait_st && cnt >= 32'(TIMEOUT - 1)) begin
      state_n = DELAY;
      abort = 1'b1;
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      {cnt, frame, nbits, temp, hi, have_temp, db_erro_medida} <= '0;
      {bus_s1, bus} <= 2'b11;
    end else begin
      bus_s1 <= dht_bus;
      bus <= bus_s1;
      cnt <= state_n != state || (ph && hi != bus) ? '0 : cnt + 1;
      hi <= ph && bus;
      nbits <= state != READ_BITS ? '0 : nbits + 6'(rb_fall);
      if (rb_fall) frame <= {frame[38:0], cnt > 32'(BIT_ONE_CYCLES)};
      if (abort) db_erro_medida <= 1'b1;
      else if (state == CHECK) begin
        db_erro_medida <= sum != frame[7:0];
        if (sum == frame[7:0]) begin
          temp <= frame[23:16];
          have_temp <= 1'b1;
        end
      end
    end
  assign db_nivel_temperatura = !have_temp ? 3'd0 : temp < 8'd20 ? 3'd1 : temp < 8'd25 ? 3'd2 :
    temp < 8'd30 ? 3'd3 : temp < 8'd35 ? 3'd4 : temp < 8'd40 ? 3'd5 : temp < 8'd45 ? 3'd6 : 3'd7;
  wire u_tick = ucnt == (ubit == 4'd0 ? 32'(CLKS_PER_BIT / 2 - 1) : 32'(CLKS_PER_BIT - 1));
  wire byte_ok = ^ush && rx;
  wire [15:0] word = {ush[7:0], lo};
  wire word_ok = lo_ok && byte_ok && !word[15] && word[14:12] != 3'd0 && word[11:4] == 8'd0 && word[3:0] <= 4'd8;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      {ucnt, ubit, ush, lo, lo_ok, have_lo, ubusy, erro_config} <= '0;
      {rx_s1, rx} <= 2'b11;
      for (int k = 0; k < 8; k++) tbl[k] <= k == 0 ? 4'd0 : 4'(k - 1);
    end else begin
      rx_s1 <= rx_serial_config;
      rx <= rx_s1;
      if (!ubusy) begin
        ubusy <= !rx;
        ucnt <= '0;
        ubit <= '0;
      end else if (u_tick) begin
        ucnt <= '0;
        ubit <= ubit + 4'd1;
        if (ubit == 4'd0 && rx) ubusy <= 1'b0;
        else if (ubit == 4'd10) begin
          ubusy <= 1'b0;
          have_lo <= !have_lo;
          if (!have_lo) begin
            lo <= ush[7:0];
            lo_ok <= byte_ok;
          end else if (word_ok) begin
            tbl[word[14:12]] <= word[3:0];
            erro_config <= 1'b0;
          end else erro_config <= 1'b1;
        end else if (ubit != 4'd0) ush <= {rx, ush[8:1]};
      end else ucnt <= ucnt + 1;
    end
  // fan level only changes at a PWM period boundary to avoid runt pulses
  wire fan_end = fcnt == 32'(8 * FAN_STEP - 1);
  wire srv_end = scnt == 32'(SERVO_PERIOD - 1);
  wire sweep_end = nper == 32'(SWEEP_PERIODS - 1);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      {fcnt, lvl, scnt, nper, side, pwm_servo} <= '0;
    end else begin
      fcnt <= fan_end ? '0 : fcnt + 1;
      if (fan_end) lvl <= tbl[db_nivel_temperatura];
      scnt <= srv_end ? '0 : scnt + 1;
      if (srv_end) nper <= sweep_end ? '0 : nper + 1;
      if (srv_end && sweep_end) side <= !side;
      pwm_servo <= scnt < (!gira ? 32'(SERVO_CENTRE) : side ? 32'(SERVO_MAX) : 32'(SERVO_MIN));
    end
  assign pwm_ventoinha = fcnt < 32'(lvl) * 32'(FAN_STEP);
  assign rele = lvl != 4'd0;
endmodule

// File: tb/tb_tusca_controller.sv
// tb_tusca_controller: directed tests of tusca_controller with shortened timing parameters.
module tb_tusca_controller;
  localparam int PD = 100, TO = 300, SL = 50, B1 = 20, CPB = 8, FS = 10;
  localparam int SP = 200, SC = 30, SMIN = 20, SMAX = 40, SW = 2;
  logic clock = 0, reset = 0, start = 0, gira = 0, rx = 1;
  logic erro_config, rele, pwm_ventoinha, pwm_servo, db_erro_medida;
  logic [2:0] band;
  wire dht_bus;
  logic s_drive = 0, s_respond = 0;
  logic [39:0] s_frame = '0;
  int frames_sent = 0;
  int checks = 0, passed = 0;
  assign dht_bus = s_drive ? 1'b0 : 1'bz;
  pullup (dht_bus);
  always #5 clock = ~clock;
  tusca_controller #(.PERIODO_DELAY(PD), .TIMEOUT(TO), .START_CYCLES(SL), .BIT_ONE_CYCLES(B1),
    .CLKS_PER_BIT(CPB), .FAN_STEP(FS), .SERVO_PERIOD(SP), .SERVO_CENTRE(SC), .SERVO_MIN(SMIN),
    .SERVO_MAX(SMAX), .SWEEP_PERIODS(SW)) dut (
    .clock(clock), .reset(reset), .start(start), .gira(gira), .rx_serial_config(rx),
    .dht_bus(dht_bus), .erro_config(erro_config), .rele(rele), .pwm_ventoinha(pwm_ventoinha),
    .pwm_servo(pwm_servo), .db_nivel_temperatura(band), .db_erro_medida(db_erro_medida));
  // DHT11 model: answers each host start pulse with the current s_frame when enabled
  initial begin : sensor
    logic [39:0] f;
    forever begin
      @(negedge clock);
      if (dht_bus === 1'b0 && !s_drive) begin
        while (dht_bus === 1'b0) @(negedge clock);
        if (s_respond) begin
          f = s_frame;
          repeat (5) @(negedge clock);
          s_drive = 1; repeat (16) @(negedge clock);
          s_drive = 0; repeat (16) @(negedge clock);
          for (int i = 39; i >= 0; i--) begin
            s_drive = 1; repeat (10) @(negedge clock);
            s_drive = 0; repeat (f[i] ? 30 : 10) @(negedge clock);
          end
          s_drive = 1; repeat (10) @(negedge clock);
          s_drive = 0;
          frames_sent++;
        end
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic wait_frames(input int n);
    int target = frames_sent + n;
    for (int c = 0; c < 4000 * n && frames_sent < target; c++) @(negedge clock);
    repeat (5) @(negedge clock);
    checks++; if (frames_sent < target) $display("FAIL frame_wait got %0d want %0d", frames_sent, target); else passed++;
  endtask
  task automatic fan_high(output int h);
    h = 0;
    for (int c = 0; c < 8 * FS; c++) begin
      @(negedge clock);
      if (pwm_ventoinha) h++;
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic flip);
    logic [10:0] fr;
    fr = {1'b1, ~^b ^ flip, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = fr[i];
      repeat (CPB) @(negedge clock);
    end
    repeat (CPB) @(negedge clock);
  endtask
  task automatic send_word(input logic [15:0] w, input logic flip_lo);
    send_byte(w[7:0], flip_lo);
    send_byte(w[15:8], 1'b0);
  endtask
  task automatic measure_pulse(output int w);
    w = 0;
    for (int c = 0; c < SP && pwm_servo !== 1'b0; c++) @(negedge clock);
    for (int c = 0; c < 2 * SP && pwm_servo !== 1'b1; c++) @(negedge clock);
    while (pwm_servo === 1'b1 && w < SP) begin
      w++;
      @(negedge clock);
    end
  endtask
  task automatic test_reset;
    reset = 0;
    repeat (3) @(negedge clock);
    checks++; if (erro_config !== 1'b0) $display("FAIL rst_erro_config got %b want 0", erro_config); else passed++;
    checks++; if (db_erro_medida !== 1'b0) $display("FAIL rst_erro_medida got %b want 0", db_erro_medida); else passed++;
    checks++; if (band !== 3'd0) $display("FAIL rst_band got %0d want 0", band); else passed++;
    checks++; if ({rele, pwm_ventoinha, pwm_servo} !== 3'b000) $display("FAIL rst_outputs got %b want 000", {rele, pwm_ventoinha, pwm_servo}); else passed++;
    checks++; if (dht_bus !== 1'b1) $display("FAIL rst_bus got %b want 1", dht_bus); else passed++;
    for (int k = 1; k < 8; k++) begin
      checks++; if (dut.tbl[k] !== 4'(k - 1)) $display("FAIL rst_table[%0d] got %0d want %0d", k, dut.tbl[k], k - 1); else passed++;
    end
    @(negedge clock) reset = 1;
    repeat (SL + 20) @(negedge clock);
    checks++; if (dht_bus !== 1'b1) $display("FAIL idle_bus got %b want 1", dht_bus); else passed++;
  endtask
  task automatic test_measure;
    int h;
    s_frame = 40'h123422026A;
    s_respond = 1;
    start = 1; @(negedge clock) start = 0;
    wait_frames(1);
    checks++; if (db_erro_medida !== 1'b0) $display("FAIL meas_erro got %b want 0", db_erro_medida); else passed++;
    checks++; if (band !== 3'd4) $display("FAIL meas_band got %0d want 4", band); else passed++;
    repeat (16 * FS) @(negedge clock);
    fan_high(h);
    checks++; if (h != 3 * FS) $display("FAIL meas_fan_high got %0d want %0d", h, 3 * FS); else passed++;
    checks++; if (rele !== 1'b1) $display("FAIL meas_rele got %b want 1", rele); else passed++;
  endtask
  task automatic test_config;
    logic [15:0] words [7] = '{16'h1000, 16'h2001, 16'h3002, 16'h4003, 16'h5004, 16'h6003, 16'h7008};
    logic [3:0] exp [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd3, 4'd8};
    int h;
    for (int i = 0; i < 7; i++) begin
      send_word(words[i], 1'b0);
      checks++; if (erro_config !== 1'b0) $display("FAIL cfg_word_%h erro got %b want 0", words[i], erro_config); else passed++;
    end
    for (int k = 1; k < 8; k++) begin
      checks++; if (dut.tbl[k] !== exp[k - 1]) $display("FAIL cfg_table[%0d] got %0d want %0d", k, dut.tbl[k], exp[k - 1]); else passed++;
    end
    repeat (16 * FS) @(negedge clock);
    fan_high(h);
    checks++; if (h != 3 * FS) $display("FAIL cfg_fan_high got %0d want %0d", h, 3 * FS); else passed++;
  endtask
  task automatic test_bad_config;
    send_word(16'h1111, 1'b0);
    checks++; if (erro_config !== 1'b1) $display("FAIL badcfg_1111 erro got %b want 1", erro_config); else passed++;
    checks++; if (dut.tbl[1] !== 4'd0) $display("FAIL badcfg_1111 table got %0d want 0", dut.tbl[1]); else passed++;
    send_word(16'h3009, 1'b0);
    checks++; if (erro_config !== 1'b1) $display("FAIL badcfg_3009 erro got %b want 1", erro_config); else passed++;
    checks++; if (dut.tbl[3] !== 4'd2) $display("FAIL badcfg_3009 table got %0d want 2", dut.tbl[3]); else passed++;
    send_word(16'h1000, 1'b0);
    checks++; if (erro_config !== 1'b0) $display("FAIL badcfg_recover erro got %b want 0", erro_config); else passed++;
    send_word(16'h2005, 1'b1);
    checks++; if (erro_config !== 1'b1) $display("FAIL badcfg_parity erro got %b want 1", erro_config); else passed++;
    checks++; if (dut.tbl[2] !== 4'd1) $display("FAIL badcfg_parity table got %0d want 1", dut.tbl[2]); else passed++;
  endtask
  task automatic test_bad_checksum;
    int h;
    s_frame = 40'h2345AAB2AB;
    wait_frames(2);
    checks++; if (db_erro_medida !== 1'b1) $display("FAIL cksum_bad erro got %b want 1", db_erro_medida); else passed++;
    checks++; if (band !== 3'd4) $display("FAIL cksum_bad band got %0d want 4", band); else passed++;
    s_frame = 40'h2345AAB2C4;
    wait_frames(2);
    checks++; if (db_erro_medida !== 1'b0) $display("FAIL cksum_good erro got %b want 0", db_erro_medida); else passed++;
    checks++; if (band !== 3'd7) $display("FAIL cksum_good band got %0d want 7", band); else passed++;
    repeat (16 * FS) @(negedge clock);
    fan_high(h);
    checks++; if (h != 8 * FS) $display("FAIL fan_full high got %0d want %0d", h, 8 * FS); else passed++;
    checks++; if (rele !== 1'b1) $display("FAIL fan_full rele got %b want 1", rele); else passed++;
  endtask
  task automatic test_timeout;
    int n = 0, m = 0;
    s_respond = 0;
    for (int c = 0; c < 5000 && !(dht_bus === 1'b0 && !s_drive); c++) @(negedge clock);
    for (int c = 0; c < SL + 10 && dht_bus !== 1'b1; c++) @(negedge clock);
    while (db_erro_medida !== 1'b1 && n < TO + 50) begin
      n++;
      @(negedge clock);
    end
    checks++; if (n < TO || n > TO + 6) $display("FAIL timeout_latency got %0d want %0d..%0d", n, TO, TO + 6); else passed++;
    while (dht_bus !== 1'b0 && m < PD + 50) begin
      m++;
      @(negedge clock);
    end
    checks++; if (m < PD - 1 || m > PD + 1) $display("FAIL timeout_delay got %0d want %0d", m, PD); else passed++;
    checks++; if (band !== 3'd7) $display("FAIL timeout_band got %0d want 7", band); else passed++;
  endtask
  task automatic test_servo;
    int w, ws [6];
    int mins_a = 0, mins_b = 0;
    gira = 0;
    measure_pulse(w);
    measure_pulse(w);
    checks++; if (w != SC) $display("FAIL servo_centre got %0d want %0d", w, SC); else passed++;
    gira = 1;
    measure_pulse(w);
    for (int i = 0; i < 6; i++) measure_pulse(ws[i]);
    for (int i = 0; i < 6; i++) begin
      checks++; if (ws[i] != SMIN && ws[i] != SMAX) $display("FAIL servo_sweep[%0d] got %0d want %0d or %0d", i, ws[i], SMIN, SMAX); else passed++;
      if (i < 4 && ws[i] == SMIN) mins_a++;
      if (i >= 2 && ws[i] == SMIN) mins_b++;
    end
    checks++; if (mins_a != 2 || mins_b != 2) $display("FAIL servo_alternation got %0d,%0d want 2,2", mins_a, mins_b); else passed++;
  endtask
  task automatic test_reset_mid;
    send_word(16'h1111, 1'b0);
    checks++; if (erro_config !== 1'b1) $display("FAIL mid_pre_erro got %b want 1", erro_config); else passed++;
    for (int c = 0; c < 5000 && dht_bus !== 1'b0; c++) @(negedge clock);
    rx = 0;
    repeat (3 * CPB) @(negedge clock);
    checks++; if (dht_bus !== 1'b0) $display("FAIL mid_bus_low got %b want 0", dht_bus); else passed++;
    #1 reset = 0;
    #1;
    checks++; if (dht_bus !== 1'b1) $display("FAIL mid_bus_release got %b want 1", dht_bus); else passed++;
    checks++; if ({erro_config, db_erro_medida, rele, pwm_ventoinha, pwm_servo} !== 5'b0) $display("FAIL mid_outputs got %b want 00000", {erro_config, db_erro_medida, rele, pwm_ventoinha, pwm_servo}); else passed++;
    checks++; if (band !== 3'd0) $display("FAIL mid_band got %0d want 0", band); else passed++;
    checks++; if (dut.tbl[7] !== 4'd6) $display("FAIL mid_table7 got %0d want 6", dut.tbl[7]); else passed++;
    rx = 1;
    @(negedge clock) reset = 1;
    for (int c = 0; c < 2 * SP && pwm_servo !== 1'b1; c++) @(negedge clock);
    repeat (3) @(negedge clock);
    checks++; if (pwm_servo !== 1'b1) $display("FAIL servo_pre_reset got %b want 1", pwm_servo); else passed++;
    #1 reset = 0;
    #1;
    checks++; if (pwm_servo !== 1'b0) $display("FAIL servo_reset got %b want 0", pwm_servo); else passed++;
    @(negedge clock) reset = 1;
    repeat (4) @(negedge clock);
    send_word(16'h1111, 1'b0);
    checks++; if (erro_config !== 1'b1) $display("FAIL post_reset_uart erro got %b want 1", erro_config); else passed++;
    send_word(16'h5002, 1'b0);
    checks++; if (erro_config !== 1'b0) $display("FAIL post_reset_good erro got %b want 0", erro_config); else passed++;
  endtask
  initial begin
    test_reset;
    test_measure;
    test_config;
    test_bad_config;
    test_bad_checksum;
    test_timeout;
    test_servo;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/tusca_controller.md
TUSCA_CONTROLLER -- requirements
Module: tusca_controller

Interface
REQ-001 Parameter PERIODO_DELAY, default 3500: clock cycles idle between end of one measurement and next DHT11 start pulse.
REQ-002 Parameter TIMEOUT, default 5000000: max clock cycles in any DHT11 wait state before abort.
REQ-003 clock  in  1  single 50 MHz system clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse; leaves IDLE and begins periodic measurement.
REQ-006 gira  in  1  1 = servo sweeps, 0 = servo parked at centre.
REQ-007 rx_serial_config  in  1  UART config line, idle high.
REQ-008 dht_bus  inout  1  DHT11 single-wire bus, open-drain: drives 0 or Z only.
REQ-009 erro_config  out  1  sticky flag, last config word rejected.
REQ-010 rele  out  1  fan power relay.
REQ-011 pwm_ventoinha  out  1  fan PWM.
REQ-012 pwm_servo  out  1  servo PWM.
REQ-013 db_nivel_temperatura  out  3  current temperature band 1..7 (0 before first valid reading).
REQ-014 db_erro_medida  out  1  last measurement failed (checksum or timeout).

Function
REQ-015 Main FSM: IDLE -> START_LOW (bus 0 for 900000 cycles) -> RELEASE (bus Z) -> WAIT_RESP_LOW -> WAIT_RESP_HIGH -> READ_BITS (40) -> CHECK -> DELAY (PERIODO_DELAY cycles) -> START_LOW.
REQ-016 Any wait state exceeding TIMEOUT cycles -> db_erro_medida=1, stored data unchanged, go to DELAY.
REQ-017 Bit decode: each bit = low phase then high phase; high phase >2000 cycles (40 us) = 1, else 0; MSB first.
REQ-018 Frame = {hum_int, hum_dec, temp_int, temp_dec, checksum}; valid iff checksum == 8-bit sum of first four bytes.
REQ-019 Valid frame: latch temp_int, clear db_erro_medida; invalid: set db_erro_medida, keep previous temp_int.
REQ-020 Bands on temp_int: <20 ->1, 20-24 ->2, 25-29 ->3, 30-34 ->4, 35-39 ->5, 40-44 ->6, >=45 ->7.
REQ-021 UART receiver: 115200 baud (434 cycles/bit), sample mid-bit; frame = start, 8 data LSB first, odd parity bit (total ones incl. parity odd), stop.
REQ-022 Config word = 2 bytes, low byte first; addr=word[15:12], value=word[3:0].
REQ-023 Word accepted iff both parities correct, addr in 1..7, word[11:4]==0, value<=8; accepted: table[addr]<=value, erro_config<=0.
REQ-024 Rejected word: table unchanged, erro_config<=1 until next accepted word or reset.
REQ-025 Config receive runs concurrently with measurement FSM, in any state including IDLE.
REQ-026 Fan level L = table[band]; band 0 -> L=0.
REQ-027 pwm_ventoinha: period 2000 cycles, high for L*250 cycles from period start (L=8 -> constant 1); L updates at period boundary only.
REQ-028 rele = 1 iff L != 0.
REQ-029 pwm_servo: period 1000000 cycles; gira=0 -> 75000-cycle pulse; gira=1 -> pulse alternates 50000/100000 every 50 periods.
REQ-030 start while not IDLE is ignored.

Reset
REQ-031 reset low: FSM IDLE, dht_bus Z, UART idle, erro_config 0, db_erro_medida 0, band 0, rele 0, pwm_ventoinha 0, pwm_servo 0, counters 0.
REQ-032 Reset table defaults: table[k] = k-1 for k=1..7.
REQ-033 Reset mid-operation (bus low, mid-UART frame) aborts immediately; bus released same instant.

Verification
REQ-034 start, sensor replies 40'h123422026A -> db_erro_medida 0, band 4 (34 C), L=3, rele 1, fan high 750/2000.
REQ-035 Words 1000,2001,3002,4003,5004,6003,7008, correct parity -> erro_config 0, table {0,1,2,3,4,3,8}; band 4 -> L=3.
REQ-036 Word 1111 -> erro_config 1, table unchanged; same byte with wrong parity -> erro_config 1.
REQ-037 Reply 40'h2345AAB2AB (bad checksum) -> db_erro_medida 1, band stays 4; next 40'h2345AAB2C4 -> band 7, L=8, pwm_ventoinha constant 1.
REQ-038 No sensor response after start pulse -> db_erro_medida 1 after TIMEOUT cycles, next start pulse after PERIODO_DELAY.
REQ-039 gira 0 -> 75000-cycle servo pulse; gira 1 -> 50000/100000 alternation; reset low mid-pulse -> pwm_servo 0 immediately.
